// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Control stage in front of a WIDTH-bit add/sub datapath. It collects operand A and then
//   operand B (with the add/sub select) from a shared data bus. The operands stay stable on
//   the adder inputs for HOLD_CYCLES clocks, and then the adder sum and flags are captured.
//   The captured result is offered to a consumer through a valid/ready handshake.
//
// Ports
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   din, din_valid, op    operand bus, 1-cycle load strobe, add(0)/sub(1) select
//   add_x, add_y, add_sel registered operands and select driven to the external adder
//   add_sum, add_cout,    external adder sum, carry out and signed overflow
//   add_ovf
//   busy                  high while the result is settling or waiting for the consumer
//   res_valid, res_ready  result handshake
//   result, res_cout,     captured sum and flags
//   res_ovf, res_neg,
//   res_zero
//   state                 FSM state for status LEDs (0 idle, 1 load B, 2 settle, 3 done)
module alu_operand_sequencer #(
  parameter int unsigned WIDTH       = 6,
  // Legal range 1..15 (4-bit hold counter).
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             op,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_sel,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_neg,
  output logic             res_zero,
  output logic [1:0]       state
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] HoldInit = CntW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoadB  = 2'd1,
    StSettle = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              neg_q, neg_d;
  logic              zero_q, zero_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    valid_d  = valid_q;

    unique case (state_q)
      StIdle: begin
        if (din_valid) begin
          a_d     = din;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        // No timeout: A is held until B arrives.
        if (din_valid) begin
          b_d     = din;
          op_d    = op;
          cnt_d   = HoldInit;
          state_d = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q - 1'b1;
        // The last hold clock is also the capture edge.
        if (cnt_q == 4'd1) begin
          result_d = add_sum;
          cout_d   = add_cout;
          ovf_d    = add_ovf;
          neg_d    = add_sum[WIDTH-1];
          zero_d   = (add_sum == '0);
          valid_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        // din_valid is deliberately ignored here, even on the handshake edge.
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign add_x     = a_q;
  assign add_y     = b_q;
  assign add_sel   = op_q;
  assign busy      = (state_q == StSettle) || (state_q == StDone);
  assign res_valid = valid_q;
  assign result    = result_q;
  assign res_cout  = cout_q;
  assign res_ovf   = ovf_q;
  assign res_neg   = neg_q;
  assign res_zero  = zero_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: instance 0 uses HOLD_CYCLES=1, instance 1 uses
// HOLD_CYCLES=4. A transaction-level model predicts every output and is compared on
// each falling edge; directed sequences add literal expectations.
module tb_alu_operand_sequencer;

  logic       clk;
  logic       rst;
  logic [5:0] din_v   [2];
  logic       dv      [2];
  logic       opv     [2];
  logic       rdy     [2];
  logic [5:0] x_v     [2];
  logic [5:0] y_v     [2];
  logic       sel_v   [2];
  logic [5:0] sum_v   [2];
  logic       cout_v  [2];
  logic       ovf_v   [2];
  logic       busy_v  [2];
  logic       valid_v [2];
  logic [5:0] res_v   [2];
  logic       rcout_v [2];
  logic       rovf_v  [2];
  logic       rneg_v  [2];
  logic       rzero_v [2];
  logic [1:0] state_v [2];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder: {cout,sum} = x + (sel ? ~y : y) + sel, plus signed overflow.
  function automatic logic [7:0] beh_add(input logic [5:0] x, input logic [5:0] y,
                                         input logic sel);
    logic [5:0] yy;
    logic [6:0] t;
    logic       ovf;
    yy  = sel ? ~y : y;
    t   = {1'b0, x} + {1'b0, yy} + {6'd0, sel};
    ovf = (x[5] == yy[5]) && (t[5] != x[5]);
    return {ovf, t};
  endfunction

  assign {ovf_v[0], cout_v[0], sum_v[0]} = beh_add(x_v[0], y_v[0], sel_v[0]);
  assign {ovf_v[1], cout_v[1], sum_v[1]} = beh_add(x_v[1], y_v[1], sel_v[1]);

  alu_operand_sequencer #(.WIDTH(6), .HOLD_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .din(din_v[0]), .din_valid(dv[0]), .op(opv[0]),
    .add_x(x_v[0]), .add_y(y_v[0]), .add_sel(sel_v[0]),
    .add_sum(sum_v[0]), .add_cout(cout_v[0]), .add_ovf(ovf_v[0]),
    .busy(busy_v[0]), .res_valid(valid_v[0]), .res_ready(rdy[0]),
    .result(res_v[0]), .res_cout(rcout_v[0]), .res_ovf(rovf_v[0]),
    .res_neg(rneg_v[0]), .res_zero(rzero_v[0]), .state(state_v[0])
  );

  alu_operand_sequencer #(.WIDTH(6), .HOLD_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .din(din_v[1]), .din_valid(dv[1]), .op(opv[1]),
    .add_x(x_v[1]), .add_y(y_v[1]), .add_sel(sel_v[1]),
    .add_sum(sum_v[1]), .add_cout(cout_v[1]), .add_ovf(ovf_v[1]),
    .busy(busy_v[1]), .res_valid(valid_v[1]), .res_ready(rdy[1]),
    .result(res_v[1]), .res_cout(rcout_v[1]), .res_ovf(rovf_v[1]),
    .res_neg(rneg_v[1]), .res_zero(rzero_v[1]), .state(state_v[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  logic [5:0] m_a [2];
  logic [5:0] m_b [2];
  logic       m_op [2];
  logic       m_have_a [2];
  int         m_wait [2];
  logic       m_valid [2];
  logic [5:0] m_res [2];
  logic       m_cout [2], m_ovf [2], m_neg [2], m_zero [2];

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Plain integer arithmetic: {zero,neg,ovf,cout,result}.
  function automatic logic [9:0] calc(input logic [5:0] a, input logic [5:0] b, input logic o);
    int ua, ub, s, sa, sb, ss;
    logic [5:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    s  = o ? ua - ub : ua + ub;
    r  = s[5:0];
    c  = o ? (ua >= ub) : (s >= 64);
    sa = a[5] ? ua - 64 : ua;
    sb = b[5] ? ub - 64 : ub;
    ss = o ? sa - sb : sa + sb;
    v  = (ss > 31) || (ss < -32);
    return {(r == 6'd0), r[5], v, c, r};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_a[i] <= '0; m_b[i] <= '0; m_op[i] <= 1'b0; m_have_a[i] <= 1'b0;
        m_wait[i] <= 0; m_valid[i] <= 1'b0; m_res[i] <= '0;
        m_cout[i] <= 1'b0; m_ovf[i] <= 1'b0; m_neg[i] <= 1'b0; m_zero[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) begin
          if (rdy[i]) m_valid[i] <= 1'b0;
        end else if (m_wait[i] > 0) begin
          m_wait[i] <= m_wait[i] - 1;
          if (m_wait[i] == 1) begin
            {m_zero[i], m_neg[i], m_ovf[i], m_cout[i], m_res[i]} <= calc(m_a[i], m_b[i], m_op[i]);
            m_valid[i] <= 1'b1;
          end
        end else if (dv[i]) begin
          if (!m_have_a[i]) begin
            m_a[i]      <= din_v[i];
            m_have_a[i] <= 1'b1;
          end else begin
            m_b[i]      <= din_v[i];
            m_op[i]     <= opv[i];
            m_wait[i]   <= hold_of(i);
            m_have_a[i] <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int exp_state;
      exp_state = m_valid[i] ? 3 : (m_wait[i] > 0) ? 2 : m_have_a[i] ? 1 : 0;
      chk($sformatf("dut%0d.state", i), int'(state_v[i]), exp_state);
      chk($sformatf("dut%0d.busy", i), int'(busy_v[i]), int'(exp_state >= 2));
      chk($sformatf("dut%0d.res_valid", i), int'(valid_v[i]), int'(m_valid[i]));
      chk($sformatf("dut%0d.add_x", i), int'(x_v[i]), int'(m_a[i]));
      chk($sformatf("dut%0d.add_y", i), int'(y_v[i]), int'(m_b[i]));
      chk($sformatf("dut%0d.add_sel", i), int'(sel_v[i]), int'(m_op[i]));
      if (m_valid[i]) begin
        chk($sformatf("dut%0d.result", i), int'(res_v[i]), int'(m_res[i]));
        chk($sformatf("dut%0d.res_cout", i), int'(rcout_v[i]), int'(m_cout[i]));
        chk($sformatf("dut%0d.res_ovf", i), int'(rovf_v[i]), int'(m_ovf[i]));
        chk($sformatf("dut%0d.res_neg", i), int'(rneg_v[i]), int'(m_neg[i]));
        chk($sformatf("dut%0d.res_zero", i), int'(rzero_v[i]), int'(m_zero[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // All tasks are entered and left on a falling edge.
  task automatic load(input int i, input logic [5:0] d, input logic o);
    din_v[i] = d;
    opv[i]   = o;
    dv[i]    = 1'b1;
    @(negedge clk);
    dv[i]    = 1'b0;
  endtask

  task automatic ack(input int i);
    rdy[i] = 1'b1;
    @(negedge clk);
    rdy[i] = 1'b0;
    chk("ack.res_valid", int'(valid_v[i]), 0);
    chk("ack.state", int'(state_v[i]), 0);
  endtask

  task automatic check_result(input int i, input int er, input int ec, input int eo,
                              input int en, input int ez);
    chk("lit.result", int'(res_v[i]), er);
    chk("lit.cout", int'(rcout_v[i]), ec);
    chk("lit.ovf", int'(rovf_v[i]), eo);
    chk("lit.neg", int'(rneg_v[i]), en);
    chk("lit.zero", int'(rzero_v[i]), ez);
    chk("model.result", int'(m_res[i]), er);
    chk("model.cout", int'(m_cout[i]), ec);
    chk("model.ovf", int'(m_ovf[i]), eo);
  endtask

  task automatic run_txn(input int i, input logic [5:0] a, input logic [5:0] b, input logic o,
                         input int er, input int ec, input int eo, input int en, input int ez);
    load(i, a, 1'b0);
    load(i, b, o);
    chk("lit.add_x", int'(x_v[i]), int'(a));
    chk("lit.add_y", int'(y_v[i]), int'(b));
    for (int k = 0; k < hold_of(i); k++) begin
      chk("lit.valid_early", int'(valid_v[i]), 0);
      @(negedge clk);
    end
    chk("lit.valid_on_time", int'(valid_v[i]), 1);
    check_result(i, er, ec, eo, en, ez);
    chk("lit.add_x_held", int'(x_v[i]), int'(a));
    chk("lit.add_y_held", int'(y_v[i]), int'(b));
    ack(i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      din_v[i] = '0; dv[i] = 1'b0; opv[i] = 1'b0; rdy[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.state", int'(state_v[0]), 0);
    chk("reset.add_x", int'(x_v[0]), 0);
    chk("reset.res_valid", int'(valid_v[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add, overflow into sign bit, subtract to zero, subtract to negative.
    run_txn(0, 6'd5,  6'd3, 1'b0, 8,  0, 0, 0, 0);
    run_txn(0, 6'd31, 6'd1, 1'b0, 32, 0, 1, 1, 0);
    run_txn(0, 6'd5,  6'd5, 1'b1, 0,  1, 0, 0, 1);
    run_txn(0, 6'd0,  6'd1, 1'b1, 63, 0, 0, 1, 0);

    // Handshake and din_valid on the same DONE edge: din is not taken as A.
    load(0, 6'd7, 1'b0);
    load(0, 6'd2, 1'b0);
    @(negedge clk);
    chk("t5.valid", int'(valid_v[0]), 1);
    din_v[0] = 6'd9; dv[0] = 1'b1; rdy[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0; rdy[0] = 1'b0;
    chk("t5.state", int'(state_v[0]), 0);
    chk("t5.res_valid", int'(valid_v[0]), 0);
    chk("t5.add_x_old", int'(x_v[0]), 7);
    load(0, 6'd9, 1'b0);
    chk("t5.add_x_new", int'(x_v[0]), 9);
    chk("t5.state_loadb", int'(state_v[0]), 1);
    load(0, 6'd1, 1'b0);
    @(negedge clk);
    check_result(0, 10, 0, 0, 0, 0);
    ack(0);

    // Asynchronous reset in the middle of SETTLE.
    load(0, 6'd10, 1'b0);
    load(0, 6'd20, 1'b0);
    chk("t6.in_settle", int'(state_v[0]), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.state", int'(state_v[0]), 0);
    chk("t6.add_x", int'(x_v[0]), 0);
    chk("t6.add_y", int'(y_v[0]), 0);
    chk("t6.res_valid", int'(valid_v[0]), 0);
    chk("t6.busy", int'(busy_v[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(0, 6'd5, 6'd3, 1'b0, 8, 0, 0, 0, 0);

    // HOLD_CYCLES=4: exact latency, ignored loads in SETTLE/DONE, long DONE.
    load(1, 6'd10, 1'b0);
    load(1, 6'd6, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t4.valid_early", int'(valid_v[1]), 0);
      chk("t4.state_settle", int'(state_v[1]), 2);
      if (k == 1) begin
        din_v[1] = 6'd50; dv[1] = 1'b1;
      end
      @(negedge clk);
      dv[1] = 1'b0;
    end
    chk("t4.valid_on_time", int'(valid_v[1]), 1);
    din_v[1] = 6'd60; dv[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dv[1] = 1'b0;
      chk("t4.done_held", int'(valid_v[1]), 1);
      chk("t4.add_x", int'(x_v[1]), 10);
      chk("t4.add_y", int'(y_v[1]), 6);
    end
    check_result(1, 16, 0, 0, 0, 0);
    ack(1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
